pseudo_random_checker: RTL and testbench

//  Receive-side partner of the 32-bit Fibonacci PRBS generator. Consumes the serial bit the generator

---
 rtl/pseudo_random_checker_pkg.sv | 12 +
 rtl/pseudo_random_checker_sat_counter.sv | 19 +
 rtl/pseudo_random_checker.sv | 97 +++++++++
 tb/tb_pseudo_random_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pseudo_random_checker_pkg.sv
// pseudo_random_checker_pkg: PRBS constants shared by generator and checker, checker FSM encoding
package pseudo_random_checker_pkg;
    localparam int PRBS_WIDTH = 32;
    localparam logic [PRBS_WIDTH-1:0] PRBS_TAP_MASK = 32'h000A28A0;
    localparam logic [PRBS_WIDTH-1:0] PRBS_ZERO_SEED = 32'hFA114514;

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} checkerState_t;

    function automatic logic prbsPredict(input logic [PRBS_WIDTH-1:0] s);
        return ^(s & PRBS_TAP_MASK);
    endfunction
endpackage

// File: rtl/pseudo_random_checker_sat_counter.sv
// prbs_sat_counter: up-counter with synchronous clear that holds at all-ones instead of wrapping
module prbs_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             iClock,
    input  logic             iReset,
    input  logic             iInc,
    input  logic             iClear,
    output logic [WIDTH-1:0] oCount
);
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            oCount <= '0;
        else if (iClear)
            oCount <= '0;
        else if (iInc && !(&oCount))
            oCount <= oCount + WIDTH'(1);
    end
endmodule

// File: rtl/pseudo_random_checker.sv
// pseudo_random_checker: self-synchronising PRBS sink with lock detection and bit/error counters
module pseudo_random_checker
    import pseudo_random_checker_pkg::*;
#(
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iValid,
    input  logic                  iBit,
    input  logic                  iClear,
    output logic                  oLocked,
    output logic                  oError,
    output logic [31:0]           oErrorCount,
    output logic [31:0]           oBitCount,
    output logic [PRBS_WIDTH-1:0] oState
);
    localparam int FILL_W   = $clog2(PRBS_WIDTH);
    localparam int VERIFY_W = $clog2(LOCK_COUNT);
    localparam int WIN_W    = $clog2(WINDOW);
    localparam int ERR_W    = $clog2(LOSS_THRESH + 1);

    checkerState_t state, nextState;
    logic [FILL_W-1:0] fillCnt;
    logic [VERIFY_W-1:0] verifyCnt;
    logic [WIN_W-1:0] windowCnt;
    logic [ERR_W-1:0] windowErr, errSum;
    logic [PRBS_WIDTH-1:0] shiftIn;
    logic pred, mis, fillDone, windowWrap, checking;

    assign pred       = prbsPredict(oState);
    assign mis        = pred ^ iBit;
    assign shiftIn    = {oState[PRBS_WIDTH-2:0], iBit};
    assign fillDone   = fillCnt == FILL_W'(PRBS_WIDTH - 1);
    assign windowWrap = windowCnt == WIN_W'(WINDOW - 1);
    assign errSum     = windowErr + ERR_W'(mis);
    assign checking   = iValid && state == LOCKED;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            state <= HUNT;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (iValid)
            case (state)
                HUNT:    nextState = (fillDone && shiftIn != '0) ? VERIFY : HUNT;
                VERIFY:  nextState = mis ? HUNT : (verifyCnt == VERIFY_W'(LOCK_COUNT - 1) ? LOCKED : VERIFY);
                LOCKED:  nextState = (errSum == ERR_W'(LOSS_THRESH)) ? HUNT : LOCKED;
                default: nextState = HUNT;
            endcase
    end

    always_comb oLocked = state == LOCKED;

    // Once locked the shadow free-runs on its own prediction, so a line error cannot corrupt it.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            oState    <= '0;
            fillCnt   <= '0;
            verifyCnt <= '0;
            windowCnt <= '0;
            windowErr <= '0;
            oError    <= 1'b0;
        end else begin
            oError <= checking && mis;
            if (iValid) begin
                oState    <= (state == LOCKED) ? {oState[PRBS_WIDTH-2:0], pred} : shiftIn;
                fillCnt   <= (state == HUNT && !fillDone) ? fillCnt + FILL_W'(1) : '0;
                verifyCnt <= (state == VERIFY) ? verifyCnt + VERIFY_W'(1) : '0;
                windowCnt <= (state == LOCKED && !windowWrap) ? windowCnt + WIN_W'(1) : '0;
                windowErr <= (state == LOCKED && !windowWrap) ? errSum : '0;
            end
        end
    end

    prbs_sat_counter #(.WIDTH(32)) uBitCount (
        .iClock (iClock),
        .iReset (iReset),
        .iInc   (checking),
        .iClear (iClear),
        .oCount (oBitCount)
    );

    prbs_sat_counter #(.WIDTH(32)) uErrorCount (
        .iClock (iClock),
        .iReset (iReset),
        .iInc   (checking && mis),
        .iClear (iClear),
        .oCount (oErrorCount)
    );
endmodule

// File: tb/tb_pseudo_random_checker.sv
// tb_pseudo_random_checker: drives a reference PRBS stream into the checker and compares against a bit-level model
module tb_pseudo_random_checker;
    import pseudo_random_checker_pkg::*;

    localparam int LOCK = 32, WIN = 64, THRESH = 8;
    localparam longint MAXC = 64'hFFFFFFFF;

    logic iClock = 1'b0, iReset = 1'b1, iValid = 1'b0, iBit = 1'b0, iClear = 1'b0;
    logic oLocked, oError;
    logic [31:0] oErrorCount, oBitCount, oState;
    logic sInc = 1'b0, sClear = 1'b0;
    logic [2:0] sCount;
    int checks = 0, errors = 0;
    logic [31:0] genValue, g;

    logic [31:0] mShadow;
    int mMode, mFill, mGood, mLockBits, mWinErrs;
    longint eBits, eErrs;
    logic eError;

    pseudo_random_checker dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iValid      (iValid),
        .iBit        (iBit),
        .iClear      (iClear),
        .oLocked     (oLocked),
        .oError      (oError),
        .oErrorCount (oErrorCount),
        .oBitCount   (oBitCount),
        .oState      (oState)
    );

    prbs_sat_counter #(.WIDTH(3)) uSat (
        .iClock (iClock),
        .iReset (iReset),
        .iInc   (sInc),
        .iClear (sClear),
        .oCount (sCount)
    );

    always #5 iClock = ~iClock;

    function automatic logic tapXor(input logic [31:0] v);
        int taps[6] = '{5, 7, 11, 13, 17, 19};
        logic r;
        r = 1'b0;
        foreach (taps[k]) r ^= v[taps[k]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mShadow = '0; mMode = 0; mFill = 0; mGood = 0; mLockBits = 0; mWinErrs = 0;
        eBits = 0; eErrs = 0; eError = 1'b0;
    endtask

    // Mode 0 = hunting, 1 = verifying, 2 = locked; window position derives from bits seen since lock.
    task automatic modelStep();
        logic p;
        eError = 1'b0;
        if (iValid) begin
            p = tapXor(mShadow);
            if (mMode == 0) begin
                mShadow = {mShadow[30:0], iBit};
                mFill++;
                if (mFill == 32) begin
                    mFill = 0;
                    if (mShadow != 0) begin mMode = 1; mGood = 0; end
                end
            end else if (mMode == 1) begin
                mShadow = {mShadow[30:0], iBit};
                mGood++;
                if (p != iBit) begin mMode = 0; mFill = 0; end
                else if (mGood == LOCK) begin mMode = 2; mLockBits = 0; mWinErrs = 0; end
            end else begin
                mShadow = {mShadow[30:0], p};
                eBits = (eBits < MAXC) ? eBits + 1 : MAXC;
                if (p != iBit) begin
                    eError = 1'b1;
                    eErrs = (eErrs < MAXC) ? eErrs + 1 : MAXC;
                    mWinErrs++;
                end
                if (mWinErrs == THRESH) begin mMode = 0; mFill = 0; end
                else if (mLockBits % WIN == WIN - 1) mWinErrs = 0;
                mLockBits++;
            end
        end
        if (iClear) begin eBits = 0; eErrs = 0; end
    endtask

    task automatic compareAll();
        chk("model_locked", {31'b0, oLocked}, {31'b0, mMode == 2});
        chk("model_error", {31'b0, oError}, {31'b0, eError});
        chk("model_errcount", oErrorCount, 32'(eErrs));
        chk("model_bitcount", oBitCount, 32'(eBits));
        chk("model_state", oState, mShadow);
    endtask

    task automatic drive(input logic v, input logic b, input logic c);
        iValid = v; iBit = b; iClear = c;
        modelStep();
        @(posedge iClock);
        @(negedge iClock);
        compareAll();
    endtask

    task automatic sendGen(input logic flip, input logic clr);
        logic b;
        b = tapXor(genValue);
        genValue = {genValue[30:0], b};
        drive(1'b1, b ^ flip, clr);
    endtask

    task automatic doReset();
        iReset = 1'b1; iValid = 1'b0; iClear = 1'b0;
        modelReset();
        @(negedge iClock);
        chk("rst_locked", {31'b0, oLocked}, 32'd0);
        chk("rst_error", {31'b0, oError}, 32'd0);
        chk("rst_errcount", oErrorCount, 32'd0);
        chk("rst_bitcount", oBitCount, 32'd0);
        chk("rst_state", oState, 32'd0);
        iReset = 1'b0;
        genValue = PRBS_ZERO_SEED;
    endtask

    initial begin
        modelReset();
        chk("tap_seed", {31'b0, tapXor(32'hFA114514)}, 32'd0);
        chk("tap_step1", {31'b0, tapXor(32'hF4228A28)}, 32'd1);
        g = PRBS_ZERO_SEED;
        repeat (2) g = {g[30:0], tapXor(g)};
        chk("gen_two_steps", g, 32'hE8451451);

        doReset();
        repeat (63) sendGen(1'b0, 1'b0);
        chk("lock_not_before_64", {31'b0, oLocked}, 32'd0);
        sendGen(1'b0, 1'b0);
        chk("lock_after_64", {31'b0, oLocked}, 32'd1);
        repeat (100) begin
            sendGen(1'b0, 1'b0);
            chk("state_tracks_gen", oState, genValue);
        end
        chk("clean_errcount", oErrorCount, 32'd0);
        chk("clean_bitcount", oBitCount, 32'd100);

        sendGen(1'b1, 1'b0);
        chk("single_err_pulse", {31'b0, oError}, 32'd1);
        chk("single_err_count", oErrorCount, 32'd1);
        chk("single_err_lock", {31'b0, oLocked}, 32'd1);
        sendGen(1'b0, 1'b0);
        chk("single_err_one_cycle", {31'b0, oError}, 32'd0);
        chk("single_err_state", oState, genValue);
        repeat (9) sendGen(1'b0, 1'b0);

        sendGen(1'b1, 1'b1);
        chk("clear_err_pulse", {31'b0, oError}, 32'd1);
        chk("clear_errcount", oErrorCount, 32'd0);
        chk("clear_bitcount", oBitCount, 32'd0);
        repeat (16) sendGen(1'b0, 1'b0);
        chk("count_after_clear", oBitCount, 32'd16);
        drive(1'b0, 1'b0, 1'b1);
        chk("idle_clear_bitcount", oBitCount, 32'd0);

        repeat (7) sendGen(1'b1, 1'b0);
        chk("loss_held_after_7", {31'b0, oLocked}, 32'd1);
        chk("loss_errcount_7", oErrorCount, 32'd7);
        sendGen(1'b1, 1'b0);
        chk("loss_dropped_after_8", {31'b0, oLocked}, 32'd0);
        chk("loss_errcount_8", oErrorCount, 32'd8);
        repeat (63) sendGen(1'b0, 1'b0);
        chk("relock_not_before_64", {31'b0, oLocked}, 32'd0);
        sendGen(1'b0, 1'b0);
        chk("relock_after_64", {31'b0, oLocked}, 32'd1);
        repeat (5) sendGen(1'b0, 1'b0);
        chk("relock_bitcount", oBitCount, 32'd13);

        #2 iReset = 1'b1;
        modelReset();
        #1;
        chk("async_rst_locked", {31'b0, oLocked}, 32'd0);
        chk("async_rst_errcount", oErrorCount, 32'd0);
        chk("async_rst_bitcount", oBitCount, 32'd0);
        chk("async_rst_state", oState, 32'd0);
        @(negedge iClock);
        iReset = 1'b0;
        genValue = PRBS_ZERO_SEED;

        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk("gap_lock_not_before_64", {31'b0, oLocked}, 32'd0);
            if ($urandom_range(0, 2) == 0 || i == 63) drive(1'b0, 1'($urandom), 1'b0);
            sendGen(1'b0, 1'b0);
        end
        chk("gap_lock_after_64", {31'b0, oLocked}, 32'd1);
        drive(1'b0, 1'b1, 1'b0);
        chk("gap_idle_no_error", {31'b0, oError}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) drive(1'b0, 1'($urandom), 1'b0);
            sendGen(i == 20, 1'b0);
        end
        chk("gap_errcount", oErrorCount, 32'd1);
        chk("gap_bitcount", oBitCount, 32'd40);

        doReset();
        repeat (200) drive(1'b1, 1'b0, 1'b0);
        chk("zero_stream_hunt", {31'b0, oLocked}, 32'd0);
        chk("zero_stream_state", oState, 32'd0);

        sInc = 1'b1;
        repeat (10) drive(1'b0, 1'b0, 1'b0);
        chk("sat_holds", {29'b0, sCount}, 32'd7);
        sInc = 1'b0; sClear = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk("sat_clear", {29'b0, sCount}, 32'd0);
        sClear = 1'b0; sInc = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        chk("sat_count_3", {29'b0, sCount}, 32'd3);
        sInc = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
